lockout_controller: RTL and testbench



---
 rtl/lock_pkg.sv | 37 +++
 rtl/tick_gen.sv | 43 ++++
 rtl/lockout_controller.sv | 212 +++++++++++++++++++++
 tb/tb_lockout_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// ---------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the keypad lock and its lockout supervisor.
//   - state_t       : supervisor state encoding (ARMED / LOCKOUT / ALARM)
//   - CODE_*        : 5-bit seven-segment display codes. Codes 0..9 are the
//                     plain digits; the constants below are the glyphs.
//   - to_bcd()      : converts 0..99 to two-digit packed BCD {tens, ones}
// ---------------------------------------------------------------------------
package lock_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_LOCKOUT = 2'd1,
        ST_ALARM   = 2'd2
    } state_t;

    localparam logic [4:0] CODE_C     = 5'b01010;
    localparam logic [4:0] CODE_L     = 5'b01011;
    localparam logic [4:0] CODE_S     = 5'b01100;
    localparam logic [4:0] CODE_D     = 5'b01101;
    localparam logic [4:0] CODE_O     = 5'b01110;
    localparam logic [4:0] CODE_P     = 5'b01111;
    localparam logic [4:0] CODE_E     = 5'b10000;
    localparam logic [4:0] CODE_N     = 5'b10001;
    localparam logic [4:0] CODE_TIRE  = 5'b10010;
    localparam logic [4:0] CODE_BLANK = 5'b10011;

    // Callers saturate to 99 before converting, so two digits always suffice.
    function automatic logic [7:0] to_bcd(input int unsigned value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 10);
        ones = 4'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Prescaler for the lockout supervisor. Counts clk cycles while run is high
// and restarts from zero whenever run is low, so the first tick after run
// rises arrives exactly TICK_DIV cycles later.
// Ports:
//   clk  in  : system clock
//   rst  in  : asynchronous active-high reset
//   run  in  : enable; low holds the prescaler at zero
//   tick out : one-cycle pulse once per TICK_DIV cycles (1 s)
//   half out : one-cycle pulse every TICK_DIV/2 cycles (blink toggle)
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick,
    output logic half
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST      = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(TICK_DIV / 2 - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!run || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick = run && (cnt_reg == LAST);
    // Two pulses per period: mid-way and at the wrap, giving a 50% square wave.
    assign half = run && (cnt_reg == HALF_LAST || cnt_reg == LAST);

endmodule

// File: rtl/lockout_controller.sv
// ---------------------------------------------------------------------------
// lockout_controller
// Failed-attempt supervisor for the keypad lock. Counts consecutive failed
// attempts, forces a timed lockout with a doubling penalty after MAX_FAIL
// failures, and latches an alarm after MAX_LOCKOUT lockouts. Only
// admin_clear (or reset) leaves the alarm.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   attempt_valid : one-cycle pulse per completed attempt
//   attempt_ok    : attempt result, qualified by attempt_valid
//   admin_clear   : one-cycle pulse, returns everything to ARMED
//   entry_en      : lock FSM may accept digits (ARMED)
//   lockout       : in LOCKOUT
//   alarm         : in ALARM
//   fail_count    : consecutive failures so far
//   remain        : remaining lockout seconds, BCD {tens, ones}
//   disp          : four 5-bit display codes, leftmost in [19:15]
//   disp_en       : disp overrides the lock FSM display
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module lockout_controller
    import lock_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int MAX_FAIL    = 3,
    parameter int PENALTY_S   = 10,
    parameter int MAX_LOCKOUT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        attempt_valid,
    input  logic        attempt_ok,
    input  logic        admin_clear,
    output logic        entry_en,
    output logic        lockout,
    output logic        alarm,
    output logic [2:0]  fail_count,
    output logic [7:0]  remain,
    output logic [19:0] disp,
    output logic        disp_en
);

    state_t     state_reg,      state_next;
    logic [2:0] fail_count_reg, fail_count_next;
    logic [2:0] lock_cnt_reg,   lock_cnt_next;
    logic [7:0] remain_reg,     remain_next;
    logic       blink_reg,      blink_next;
    logic       entry_en_reg,   lockout_reg, alarm_reg, disp_en_reg;

    logic       run;
    logic       tick;
    logic       half;
    logic [2:0] lock_inc;
    logic [4:0] digit_next [4];

    // Penalty for the n-th lockout (n >= 1): PENALTY_S * 2^(n-1), capped at 99.
    function automatic logic [7:0] penalty_bcd(input logic [2:0] n);
        int unsigned secs;
        secs = 32'(PENALTY_S) << (n - 3'd1);
        if (secs > 99) begin
            secs = 99;
        end
        return to_bcd(secs);
    endfunction

    // Clearing the prescaler on admin_clear takes effect on the same edge
    // that returns the FSM to ARMED.
    assign run = (state_reg != ST_ARMED) && !admin_clear;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick),
        .half (half)
    );

    assign lock_inc = lock_cnt_reg + 3'd1;

    // Next-state and counter logic
    always_comb begin
        state_next      = state_reg;
        fail_count_next = fail_count_reg;
        lock_cnt_next   = lock_cnt_reg;
        remain_next     = remain_reg;

        if (admin_clear) begin
            state_next      = ST_ARMED;
            fail_count_next = 3'd0;
            lock_cnt_next   = 3'd0;
            remain_next     = 8'h00;
        end else begin
            case (state_reg)
                ST_ARMED: begin
                    if (attempt_valid) begin
                        if (attempt_ok) begin
                            fail_count_next = 3'd0;
                            lock_cnt_next   = 3'd0;
                        end else if (int'(fail_count_reg) < MAX_FAIL - 1) begin
                            fail_count_next = fail_count_reg + 3'd1;
                        end else begin
                            fail_count_next = 3'd0;
                            lock_cnt_next   = lock_inc;
                            if (int'(lock_inc) == MAX_LOCKOUT) begin
                                state_next = ST_ALARM;
                            end else begin
                                state_next  = ST_LOCKOUT;
                                remain_next = penalty_bcd(lock_inc);
                            end
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (tick) begin
                        if (remain_reg == 8'h01) begin
                            state_next  = ST_ARMED;
                            remain_next = 8'h00;
                        end else if (remain_reg[3:0] == 4'd0) begin
                            remain_next = {remain_reg[7:4] - 4'd1, 4'd9};
                        end else begin
                            remain_next = {remain_reg[7:4], remain_reg[3:0] - 4'd1};
                        end
                    end
                end
                default: begin
                    // ALARM holds until admin_clear.
                end
            endcase
        end
    end

    // Blink restarts at 0 on every entry into LOCKOUT/ALARM.
    always_comb begin
        blink_next = blink_reg;
        if (state_next == ST_ARMED || state_reg == ST_ARMED) begin
            blink_next = 1'b0;
        end else if (half) begin
            blink_next = ~blink_reg;
        end
    end

    // Display content decoded from the next state so the registered display
    // changes on the same edge as the state.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_next[i] = CODE_BLANK;
        end
        case (state_next)
            ST_LOCKOUT: begin
                digit_next[3] = CODE_L;
                digit_next[1] = {1'b0, remain_next[7:4]};
                digit_next[0] = {1'b0, remain_next[3:0]};
            end
            ST_ALARM: begin
                for (int i = 0; i < 4; i++) begin
                    digit_next[i] = blink_next ? CODE_TIRE : CODE_BLANK;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_ARMED;
            fail_count_reg <= 3'd0;
            lock_cnt_reg   <= 3'd0;
            remain_reg     <= 8'h00;
            blink_reg      <= 1'b0;
            entry_en_reg   <= 1'b1;
            lockout_reg    <= 1'b0;
            alarm_reg      <= 1'b0;
            disp_en_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fail_count_reg <= fail_count_next;
            lock_cnt_reg   <= lock_cnt_next;
            remain_reg     <= remain_next;
            blink_reg      <= blink_next;
            entry_en_reg   <= (state_next == ST_ARMED);
            lockout_reg    <= (state_next == ST_LOCKOUT);
            alarm_reg      <= (state_next == ST_ALARM);
            disp_en_reg    <= (state_next != ST_ARMED);
        end
    end

    // One register per display digit; gi = 3 is the leftmost position.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [4:0] digit_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                digit_reg <= CODE_BLANK;
            end else begin
                digit_reg <= digit_next[gi];
            end
        end

        assign disp[gi*5 +: 5] = digit_reg;
    end

    assign entry_en   = entry_en_reg;
    assign lockout    = lockout_reg;
    assign alarm      = alarm_reg;
    assign disp_en    = disp_en_reg;
    assign fail_count = fail_count_reg;
    assign remain     = remain_reg;

endmodule

// File: tb/tb_lockout_controller.sv
module tb_lockout_controller;

    localparam logic [19:0] BLANK4 = {5'b10011, 5'b10011, 5'b10011, 5'b10011};
    localparam logic [19:0] TIRE4  = {5'b10010, 5'b10010, 5'b10010, 5'b10010};
    localparam logic [19:0] LOCK10 = {5'b01011, 5'b10011, 5'b00001, 5'b00000};

    logic        clk = 1'b0;
    logic        rst;
    logic        av, ok, clr;
    logic        av2, ok2, clr2;

    logic        entry_en, lockout, alarm, disp_en;
    logic [2:0]  fail_count;
    logic [7:0]  remain;
    logic [19:0] disp;

    logic        entry_en2, lockout2, alarm2, disp_en2;
    logic [2:0]  fail_count2;
    logic [7:0]  remain2;
    logic [19:0] disp2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lockout_controller #(
        .TICK_DIV(10), .MAX_FAIL(3), .PENALTY_S(10), .MAX_LOCKOUT(3)
    ) u_dut (
        .clk(clk), .rst(rst),
        .attempt_valid(av), .attempt_ok(ok), .admin_clear(clr),
        .entry_en(entry_en), .lockout(lockout), .alarm(alarm),
        .fail_count(fail_count), .remain(remain),
        .disp(disp), .disp_en(disp_en)
    );

    lockout_controller #(
        .TICK_DIV(10), .MAX_FAIL(3), .PENALTY_S(60), .MAX_LOCKOUT(3)
    ) u_cap (
        .clk(clk), .rst(rst),
        .attempt_valid(av2), .attempt_ok(ok2), .admin_clear(clr2),
        .entry_en(entry_en2), .lockout(lockout2), .alarm(alarm2),
        .fail_count(fail_count2), .remain(remain2),
        .disp(disp2), .disp_en(disp_en2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("check %s = %0h", tag, got);
        end
    endtask

    // Called at a falling edge; returns one falling edge later.
    task automatic attempt(input logic result);
        av = 1'b1; ok = result;
        @(negedge clk);
        av = 1'b0; ok = 1'b0;
    endtask

    task automatic attempt2(input logic result);
        av2 = 1'b1; ok2 = result;
        @(negedge clk);
        av2 = 1'b0; ok2 = 1'b0;
    endtask

    task automatic admin_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        av = 1'b0; ok = 1'b0; clr = 1'b0;
        av2 = 1'b0; ok2 = 1'b0; clr2 = 1'b0;
        cycles(3);

        // Reset values
        check("rst_entry_en", 32'(entry_en), 32'd1);
        check("rst_lockout", 32'(lockout), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_fail_count", 32'(fail_count), 32'd0);
        check("rst_remain", 32'(remain), 32'h00);
        check("rst_disp", 32'(disp), 32'(BLANK4));
        check("rst_disp_en", 32'(disp_en), 32'd0);
        check("rst_cap_entry_en", 32'(entry_en2), 32'd1);
        rst = 1'b0;
        cycles(1);

        // Two failures then a success
        attempt(1'b0); check("fail_cnt_1", 32'(fail_count), 32'd1);
        attempt(1'b0); check("fail_cnt_2", 32'(fail_count), 32'd2);
        check("fail2_entry_en", 32'(entry_en), 32'd1);
        attempt(1'b1); check("ok_fail_cnt_0", 32'(fail_count), 32'd0);
        check("ok_entry_en", 32'(entry_en), 32'd1);
        check("ok_lockout", 32'(lockout), 32'd0);

        // First lockout: 10 s
        attempt(1'b0); attempt(1'b0); attempt(1'b0);
        check("lk1_lockout", 32'(lockout), 32'd1);
        check("lk1_entry_en", 32'(entry_en), 32'd0);
        check("lk1_remain", 32'(remain), 32'h10);
        check("lk1_disp", 32'(disp), 32'(LOCK10));
        check("lk1_disp_en", 32'(disp_en), 32'd1);
        check("lk1_fail_cnt", 32'(fail_count), 32'd0);
        attempt(1'b0);
        check("lk1_ignored_attempt", 32'(fail_count), 32'd0);
        cycles(8);  check("lk1_remain_p9", 32'(remain), 32'h10);
        cycles(1);  check("lk1_remain_p10", 32'(remain), 32'h09);
        cycles(89); check("lk1_remain_p99", 32'(remain), 32'h01);
        check("lk1_still_locked", 32'(lockout), 32'd1);
        cycles(1);
        check("lk1_end_lockout", 32'(lockout), 32'd0);
        check("lk1_end_remain", 32'(remain), 32'h00);
        check("lk1_end_entry_en", 32'(entry_en), 32'd1);
        check("lk1_end_disp", 32'(disp), 32'(BLANK4));
        check("lk1_end_disp_en", 32'(disp_en), 32'd0);

        // Second lockout: 20 s, BCD borrow checks
        attempt(1'b0); attempt(1'b0); attempt(1'b0);
        check("lk2_remain", 32'(remain), 32'h20);
        cycles(10); check("lk2_remain_19", 32'(remain), 32'h19);
        cycles(90); check("lk2_remain_10", 32'(remain), 32'h10);
        cycles(10); check("lk2_remain_09", 32'(remain), 32'h09);
        cycles(90); check("lk2_end_lockout", 32'(lockout), 32'd0);
        check("lk2_end_remain", 32'(remain), 32'h00);

        // Third lockout request: alarm
        attempt(1'b0); attempt(1'b0); attempt(1'b0);
        check("alm_alarm", 32'(alarm), 32'd1);
        check("alm_entry_en", 32'(entry_en), 32'd0);
        check("alm_lockout", 32'(lockout), 32'd0);
        check("alm_disp_en", 32'(disp_en), 32'd1);
        check("alm_disp_p0", 32'(disp), 32'(BLANK4));
        cycles(4); check("alm_disp_p4", 32'(disp), 32'(BLANK4));
        cycles(1); check("alm_disp_p5", 32'(disp), 32'(TIRE4));
        attempt(1'b1);
        check("alm_ok_ignored", 32'(alarm), 32'd1);
        cycles(3); check("alm_disp_p9", 32'(disp), 32'(TIRE4));
        cycles(1); check("alm_disp_p10", 32'(disp), 32'(BLANK4));
        cycles(205);
        check("alm_hold", 32'(alarm), 32'd1);
        check("alm_disp_p215", 32'(disp), 32'(TIRE4));

        // admin_clear out of ALARM clears the lockout history
        admin_pulse();
        check("clr_alarm", 32'(alarm), 32'd0);
        check("clr_entry_en", 32'(entry_en), 32'd1);
        check("clr_disp_en", 32'(disp_en), 32'd0);
        check("clr_disp", 32'(disp), 32'(BLANK4));
        attempt(1'b0); attempt(1'b0); attempt(1'b0);
        check("clr_lk_remain", 32'(remain), 32'h10);
        check("clr_lk_lockout", 32'(lockout), 32'd1);
        cycles(3);
        admin_pulse();
        check("clr_in_lk_lockout", 32'(lockout), 32'd0);
        check("clr_in_lk_remain", 32'(remain), 32'h00);
        check("clr_in_lk_entry_en", 32'(entry_en), 32'd1);

        // admin_clear together with the third failing attempt
        attempt(1'b0); attempt(1'b0);
        av = 1'b1; ok = 1'b0; clr = 1'b1;
        @(negedge clk);
        av = 1'b0; clr = 1'b0;
        check("coinc_lockout", 32'(lockout), 32'd0);
        check("coinc_fail_cnt", 32'(fail_count), 32'd0);
        check("coinc_entry_en", 32'(entry_en), 32'd1);
        attempt(1'b0);
        check("coinc_after_fail", 32'(fail_count), 32'd1);

        // Asynchronous reset in the middle of a lockout
        attempt(1'b0); attempt(1'b0);
        check("arst_pre_lockout", 32'(lockout), 32'd1);
        cycles(20);
        check("arst_pre_remain", 32'(remain), 32'h08);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_lockout", 32'(lockout), 32'd0);
        check("arst_entry_en", 32'(entry_en), 32'd1);
        check("arst_remain", 32'(remain), 32'h00);
        check("arst_disp", 32'(disp), 32'(BLANK4));
        check("arst_disp_en", 32'(disp_en), 32'd0);
        check("arst_fail_cnt", 32'(fail_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles(1);
        attempt(1'b0); attempt(1'b0); attempt(1'b0);
        check("arst_history_lost", 32'(remain), 32'h10);
        admin_pulse();

        // Penalty cap with PENALTY_S = 60
        attempt2(1'b0); attempt2(1'b0); attempt2(1'b0);
        check("cap_lk1_remain", 32'(remain2), 32'h60);
        cycles(600);
        check("cap_lk1_end", 32'(lockout2), 32'd0);
        attempt2(1'b0); attempt2(1'b0); attempt2(1'b0);
        check("cap_lk2_remain", 32'(remain2), 32'h99);
        check("cap_lk2_lockout", 32'(lockout2), 32'd1);
        cycles(10);
        check("cap_lk2_remain_98", 32'(remain2), 32'h98);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
